// File: rtl/imm_pkg.sv
// Shared definitions for the pipelined immediate generator: ImmSel encoding
// and the supported datapath widths.
package imm_pkg;

    typedef enum logic [2:0] {
        IMM_I     = 3'd0,
        IMM_S     = 3'd1,
        IMM_B     = 3'd2,
        IMM_U     = 3'd3,
        IMM_J     = 3'd4,
        IMM_SHAMT = 3'd5,
        IMM_ZIMM  = 3'd6,
        IMM_ILL   = 3'd7
    } imm_sel_e;

    localparam int XLEN_RV32 = 32;
    localparam int XLEN_RV64 = 64;

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction: reorders instruction fields per ImmSel
// and sign- or zero-extends them to XLEN.
module imm_extract
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_instr,
    input  logic [2:0]      i_sel,
    output logic [XLEN-1:0] o_imm,
    output logic            o_err
);

    logic [31:0]     w_raw;
    logic            w_sext;
    logic [XLEN-1:0] w_ext_mask;
    logic            w_unused_opcode;

    // Opcode bits never contribute to any immediate.
    assign w_unused_opcode = ^i_instr[6:0];

    // Field selection; w_raw is already sign-extended to 32 bits for signed formats.
    always_comb begin
        w_raw  = 32'd0;
        w_sext = 1'b0;
        o_err  = 1'b0;
        case (imm_sel_e'(i_sel))
            IMM_I: begin
                w_raw  = {{20{i_instr[31]}}, i_instr[31:20]};
                w_sext = 1'b1;
            end
            IMM_S: begin
                w_raw  = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
                w_sext = 1'b1;
            end
            IMM_B: begin
                w_raw  = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                          i_instr[30:25], i_instr[11:8], 1'b0};
                w_sext = 1'b1;
            end
            IMM_U: begin
                w_raw  = {i_instr[31:12], 12'd0};
                w_sext = 1'b1;
            end
            IMM_J: begin
                w_raw  = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                          i_instr[20], i_instr[30:21], 1'b0};
                w_sext = 1'b1;
            end
            IMM_SHAMT: begin
                w_raw = (XLEN == XLEN_RV64) ? {26'd0, i_instr[25:20]}
                                            : {27'd0, i_instr[24:20]};
            end
            IMM_ZIMM: begin
                w_raw = {27'd0, i_instr[19:15]};
            end
            IMM_ILL: begin
                o_err = 1'b1;
            end
            default: begin
                o_err = 1'b1;
            end
        endcase
    end

    // Upper XLEN-32 bits; empty when XLEN is 32.
    assign w_ext_mask = ~XLEN'(32'hFFFF_FFFF);
    assign o_imm = (w_sext && w_raw[31]) ? (XLEN'(w_raw) | w_ext_mask) : XLEN'(w_raw);

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: one-cycle latency with a 2-entry skid buffer
// (output register + skid register), synchronous flush and illegal-select counter.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_sel,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_err,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] err_cnt
);

    logic [XLEN-1:0]  w_imm;
    logic             w_err;
    logic             w_accept;
    logic             w_out_fire;
    logic             w_load_out;
    logic             w_load_skid;

    logic             r_out_valid;
    logic [XLEN-1:0]  r_out_imm;
    logic             r_out_err;
    logic [TAG_W-1:0] r_out_tag;
    logic             r_skid_valid;
    logic [XLEN-1:0]  r_skid_imm;
    logic             r_skid_err;
    logic [TAG_W-1:0] r_skid_tag;
    logic [CNT_W-1:0] r_err_cnt;

    imm_extract #(.XLEN(XLEN)) u_extract (
        .i_instr (in_instr),
        .i_sel   (in_sel),
        .o_imm   (w_imm),
        .o_err   (w_err)
    );

    assign in_ready    = !r_skid_valid;
    assign w_accept    = in_valid && in_ready;
    assign w_out_fire  = r_out_valid && out_ready;
    assign w_load_out  = w_accept && (!r_out_valid || out_ready);
    assign w_load_skid = w_accept && !w_load_out;

    // Output/skid registers; skid is only ever occupied while the output is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_imm    <= '0;
            r_out_err    <= 1'b0;
            r_out_tag    <= '0;
            r_skid_valid <= 1'b0;
            r_skid_imm   <= '0;
            r_skid_err   <= 1'b0;
            r_skid_tag   <= '0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_load_out) begin
            r_out_valid <= 1'b1;
            r_out_imm   <= w_imm;
            r_out_err   <= w_err;
            r_out_tag   <= in_tag;
        end else if (w_load_skid) begin
            r_skid_valid <= 1'b1;
            r_skid_imm   <= w_imm;
            r_skid_err   <= w_err;
            r_skid_tag   <= in_tag;
        end else if (w_out_fire && r_skid_valid) begin
            r_out_imm    <= r_skid_imm;
            r_out_err    <= r_skid_err;
            r_out_tag    <= r_skid_tag;
            r_skid_valid <= 1'b0;
        end else if (w_out_fire) begin
            r_out_valid <= 1'b0;
        end
    end

    // Counts every accepted illegal select, flushed or not, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (w_accept && w_err && (r_err_cnt != {CNT_W{1'b1}})) begin
            r_err_cnt <= r_err_cnt + CNT_W'(1);
        end
    end

    assign out_valid = r_out_valid;
    assign out_imm   = r_out_imm;
    assign out_err   = r_out_err;
    assign out_tag   = r_out_tag;
    assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: two instances (XLEN=32/CNT_W=16 and XLEN=64/CNT_W=2)
// share stimulus; a queue scoreboard checks every output transfer.
module tb_imm_gen_pipe;
    import imm_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] in_instr = 32'd0;
    logic [2:0]  in_sel = 3'd0;
    logic [7:0]  in_tag = 8'd0;

    logic        a_in_ready, a_out_valid, a_out_err;
    logic [31:0] a_out_imm;
    logic [7:0]  a_out_tag;
    logic [15:0] a_err_cnt;
    logic        b_in_ready, b_out_valid, b_out_err;
    logic [63:0] b_out_imm;
    logic [7:0]  b_out_tag;
    logic [1:0]  b_err_cnt;

    imm_gen_pipe #(.XLEN(32), .TAG_W(8), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_instr(in_instr),
        .in_sel(in_sel), .in_tag(in_tag),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_imm(a_out_imm),
        .out_err(a_out_err), .out_tag(a_out_tag), .err_cnt(a_err_cnt)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(8), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_instr(in_instr),
        .in_sel(in_sel), .in_tag(in_tag),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_imm(b_out_imm),
        .out_err(b_out_err), .out_tag(b_out_tag), .err_cnt(b_err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ins;
        logic [2:0]  sel;
        logic [31:0] e32;
        logic [63:0] e64;
        logic        err;
    } vec_t;

    typedef struct {
        logic [7:0]  tag;
        logic [31:0] e32;
        logic [63:0] e64;
        logic        err;
        int          cyc;
    } sb_t;

    sb_t  sb[$];
    vec_t vt[10];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    bit   lat_chk = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Drive one instruction, wait for acceptance, record the expectation.
    task automatic send(input logic [31:0] ins, input logic [2:0] sel, input logic [7:0] tag,
                        input logic [31:0] e32, input logic [63:0] e64, input logic err);
        int n = 0;
        in_valid = 1'b1;
        in_instr = ins;
        in_sel   = sel;
        in_tag   = tag;
        @(negedge clk);
        while (!a_in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!a_in_ready) begin
            chk("send_timeout", 64'(a_in_ready), 64'd1);
        end else begin
            sb.push_back('{tag, e32, e64, err, cyc});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: compare each output transfer against the oldest expectation.
    always @(negedge clk) begin
        sb_t e;
        if (!rst_n || flush) begin
            sb.delete();
        end else if (a_out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output_tag", 64'(a_out_tag), 64'hFFFF);
            end else begin
                e = sb.pop_front();
                chk("tag32", 64'(a_out_tag), 64'(e.tag));
                chk("imm32", 64'(a_out_imm), 64'(e.e32));
                chk("err32", 64'(a_out_err), 64'(e.err));
                chk("valid64", 64'(b_out_valid), 64'd1);
                chk("tag64", 64'(b_out_tag), 64'(e.tag));
                chk("imm64", b_out_imm, e.e64);
                chk("err64", 64'(b_out_err), 64'(e.err));
                if (lat_chk) chk("latency", 64'(cyc - e.cyc), 64'd1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{32'hFFF00093, 3'd0, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 1'b0};
        vt[1] = '{32'h00112623, 3'd1, 32'h0000000C, 64'h00000000_0000000C, 1'b0};
        vt[2] = '{32'hFF9FF06F, 3'd4, 32'hFFFFFFF8, 64'hFFFFFFFF_FFFFFFF8, 1'b0};
        vt[3] = '{32'h123452B7, 3'd3, 32'h12345000, 64'h00000000_12345000, 1'b0};
        vt[4] = '{32'h4030D093, 3'd5, 32'h00000003, 64'h00000000_00000003, 1'b0};
        vt[5] = '{32'h0230D093, 3'd5, 32'h00000003, 64'h00000000_00000023, 1'b0};
        vt[6] = '{32'h3400D073, 3'd6, 32'h00000001, 64'h00000000_00000001, 1'b0};
        vt[7] = '{32'h800002B7, 3'd3, 32'h80000000, 64'hFFFFFFFF_80000000, 1'b0};
        vt[8] = '{32'hFE000EE3, 3'd2, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 1'b0};
        vt[9] = '{32'h7FF00093, 3'd0, 32'h000007FF, 64'h00000000_000007FF, 1'b0};

        // Reset state
        @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_out_imm", 64'(a_out_imm), 64'd0);
        chk("rst_out_err", 64'(a_out_err), 64'd0);
        chk("rst_out_tag", 64'(a_out_tag), 64'd0);
        chk("rst_err_cnt", 64'(a_err_cnt), 64'd0);
        chk("rst_out_valid64", 64'(b_out_valid), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        chk("rst_in_ready", 64'(a_in_ready), 64'd1);
        chk("rst_in_ready64", 64'(b_in_ready), 64'd1);

        // Formats, no backpressure, one-cycle latency
        lat_chk = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send(vt[i].ins, vt[i].sel, 8'(i + 16), vt[i].e32, vt[i].e64, vt[i].err);
        end
        idle(3);
        chk("table_drained", 64'(sb.size()), 64'd0);
        lat_chk = 1'b0;

        // Backpressure: tags 1,2,3 with consumer stalled
        out_ready = 1'b0;
        send(32'h00100093, 3'd0, 8'd1, 32'h1, 64'h1, 1'b0);
        send(32'h00200093, 3'd0, 8'd2, 32'h2, 64'h2, 1'b0);
        chk("bp_in_ready_full", 64'(a_in_ready), 64'd0);
        fork
            send(32'hFFF00093, 3'd0, 8'd3, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 1'b0);
            begin
                @(posedge clk);
                @(posedge clk);
                #1;
                chk("bp_in_ready_hold", 64'(a_in_ready), 64'd0);
                chk("bp_stall_tag", 64'(a_out_tag), 64'd1);
                chk("bp_stall_imm", 64'(a_out_imm), 64'd1);
                out_ready = 1'b1;
            end
        join
        idle(4);
        chk("bp_drained", 64'(sb.size()), 64'd0);
        chk("bp_out_valid_idle", 64'(a_out_valid), 64'd0);

        // Illegal select and counter saturation on the CNT_W=2 instance
        for (int i = 0; i < 3; i++) begin
            send(32'hFFFFFFFF, 3'd7, 8'(40 + i), 32'd0, 64'd0, 1'b1);
        end
        chk("ill_cnt3", 64'(a_err_cnt), 64'd3);
        chk("ill_cnt3_w2", 64'(b_err_cnt), 64'd3);
        send(32'hFFFFFFFF, 3'd7, 8'd43, 32'd0, 64'd0, 1'b1);
        chk("ill_cnt4", 64'(a_err_cnt), 64'd4);
        chk("ill_sat_w2", 64'(b_err_cnt), 64'd3);
        idle(3);
        chk("ill_drained", 64'(sb.size()), 64'd0);

        // Flush with both entries full and an input pending
        out_ready = 1'b0;
        send(32'h00500093, 3'd0, 8'd10, 32'h5, 64'h5, 1'b0);
        send(32'h00600093, 3'd0, 8'd11, 32'h6, 64'h6, 1'b0);
        in_valid = 1'b1;
        in_instr = 32'hFFFFFFFF;
        in_sel   = 3'd7;
        in_tag   = 8'd12;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", 64'(a_out_valid), 64'd0);
        chk("flush_in_ready", 64'(a_in_ready), 64'd1);
        chk("flush_err_cnt", 64'(a_err_cnt), 64'd4);
        chk("flush_err_cnt_w2", 64'(b_err_cnt), 64'd3);
        idle(2);
        chk("flush_discard", 64'(a_out_valid), 64'd0);

        // Asynchronous reset with both entries full
        send(32'h00700093, 3'd0, 8'd20, 32'h7, 64'h7, 1'b0);
        send(32'h00800093, 3'd0, 8'd21, 32'h8, 64'h8, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(a_out_valid), 64'd0);
        chk("arst_in_ready", 64'(a_in_ready), 64'd1);
        chk("arst_out_tag", 64'(a_out_tag), 64'd0);
        chk("arst_out_imm64", b_out_imm, 64'd0);
        chk("arst_err_cnt", 64'(a_err_cnt), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        idle(1);
        chk("arst_no_ghost", 64'(a_out_valid), 64'd0);
        lat_chk = 1'b1;
        send(32'h12345037, 3'd3, 8'd30, 32'h12345000, 64'h12345000, 1'b0);
        idle(3);
        chk("arst_drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, pipelined successor to the combinational immediate generator in the decode path.
- Extracts, reorders and sign- or zero-extends RISC-V immediates to XLEN bits. Adds shift-amount and CSR-zimm formats, an illegal-select flag, and a saturating error counter.
- Sits between instruction fetch/decode and the execute operand mux.
- Uses a valid/ready handshake with a 2-entry skid buffer, so backpressure from execute never drops or reorders instructions.

Parameters:
- XLEN, 32, datapath width; legal values are 32 and 64.
- TAG_W, 8, width of the opaque sideband tag (PC index, ROB id) carried alongside each immediate.
- CNT_W, 16, width of the saturating error counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  input instruction valid.
- in_ready  out  1  block can accept an input.
- in_instr  in  32  raw instruction word.
- in_sel  in  3  ImmSel from the control unit.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  output valid.
- out_ready  in  1  consumer accepts the output.
- out_imm  out  XLEN  extended immediate.
- out_err  out  1  in_sel was illegal (111) for this entry.
- out_tag  out  TAG_W  tag returned with its immediate.
- err_cnt  out  CNT_W  count of accepted illegal selects; saturates at all-ones.

Behaviour:
- Reset, asynchronous on rst_n low: out_valid=0, skid valid=0, out_imm=0, out_err=0, out_tag=0, err_cnt=0. in_ready reads 1 one cycle after reset release; it is combinational from the skid-valid register.
- Input accept: in_valid && in_ready. Output transfer: out_valid && out_ready.
- in_ready = !skid_valid.
- Latency is 1 cycle. An input accepted in cycle N appears on out_* in cycle N+1 when the output stage is empty or draining.
- On accept:
  - If !out_valid or out_ready: load the output register.
  - Otherwise: load the skid register.
- On output transfer with skid_valid=1: the skid contents move to the output register and skid_valid clears. An input arriving in the same cycle cannot occur, because in_ready=0.
- On output transfer with skid_valid=0 and no accept: out_valid clears.
- Ordering is strictly FIFO. A full buffer (both registers valid) deasserts in_ready.
- flush, synchronous: clears out_valid and skid_valid and discards any input in the same cycle. err_cnt is unaffected. flush has priority over all handshake events.
- Immediate formats, with sext meaning sign extension from Instr[31] up to XLEN:
  - 000 I: sext(Instr[31:20]).
  - 001 S: sext({Instr[31:25], Instr[11:7]}).
  - 010 B: sext({Instr[31], Instr[7], Instr[30:25], Instr[11:8], 0}).
  - 011 U: sext({Instr[31:12], 12'b0}). On XLEN=64, bits 63:32 are copies of Instr[31].
  - 100 J: sext({Instr[31], Instr[19:12], Instr[20], Instr[30:21], 0}).
  - 101 SHAMT: zero-extended Instr[24:20] when XLEN=32, Instr[25:20] when XLEN=64. Funct bits such as the srai bit 30 never leak into the value.
  - 110 ZIMM: zero-extended Instr[19:15], the CSR immediate.
  - 111: out_imm=0, out_err=1.
- err_cnt increments by 1 on each accepted sel=111, including accepts later discarded by flush. It holds at 2^CNT_W−1 once reached.
- Output registers hold their values while out_valid && !out_ready. out_imm and out_tag are stable under stall.
- Reset asserted mid-transfer: all valid state is lost immediately. No output may appear after reset until a new accept.

Decomposition:
- Shared package imm_pkg holds:
  - the ImmSel enum IMM_I=0, IMM_S, IMM_B, IMM_U, IMM_J, IMM_SHAMT, IMM_ZIMM, IMM_ILL=7.
  - the XLEN legality constants.
- Natural sub-module: imm_extract, purely combinational (instr, sel → imm, err), parametrised by XLEN. It is instantiated once, on the input side, before the skid logic.
- The top level owns the skid buffer, flush handling and err_cnt.

Test Plan:
- XLEN=32, no backpressure:
  - 0xFFF00093 with I → 0xFFFFFFFF.
  - 0x00112623 with S → 0x0000000C.
  - 0xFF9FF06F with J → 0xFFFFFFF8.
  - 0x123452B7 with U → 0x12345000.
  - Each appears 1 cycle after accept with its tag.
- SHAMT/ZIMM:
  - 0x4030D093 with SHAMT → 0x00000003. Bit 30 is excluded.
  - 0x3400D073 with ZIMM → 0x00000001.
  - XLEN=64, 0x8000_02B7 with U → 0xFFFFFFFF80000000.
- Backpressure: hold out_ready=0 and issue tags 1,2,3 back-to-back → in_ready drops after tag 2 is accepted. Releasing out_ready delivers 1,2 then 3, with no loss and no duplicates.
- Illegal select: 3 accepts with sel=111 → out_err=1, out_imm=0 each time, err_cnt=3. With CNT_W=2, a 4th accept leaves err_cnt at 3.
- Flush with both entries valid and in_valid=1 → next cycle out_valid=0, in_ready=1, input discarded, err_cnt unchanged.
- Assert rst_n low asynchronously while out_valid=1 and skid full → outputs clear immediately, without waiting for a clock edge. After release, the first output is the first new accept.
